// File: rtl/cnt_match_timer_pkg.sv
// Shared encodings and default widths for the counter consumer blocks.
// Keeping them here keeps the counter and its consumers width-consistent.
package cnt_match_timer_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/cnt_adv_detect.sv
// Tracks the previous counter sample and flags advances and all-ones -> 0 wraps.
// Reusable by any consumer of a counter Q bus.
module cnt_adv_detect
  import cnt_match_timer_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         CLK,
  input  logic         EN,
  input  logic [N-1:0] CNT,
  output logic [N-1:0] prev,
  output logic         adv,
  output logic         wrap_evt
);

  logic prev_valid;

  always_ff @(posedge CLK or negedge EN) begin
    if (!EN) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev       <= CNT;
      prev_valid <= 1'b1;
    end
  end

  // The first edge after clear only seeds prev, so no event can fire on it.
  assign adv      = prev_valid & (CNT != prev);
  assign wrap_evt = adv & (&prev) & (CNT == '0);

endmodule

// File: rtl/cnt_match_timer.sv
// Match/wrap timer on a counter Q bus: HIT/WRAP pulses, saturating wrap tally,
// and an arm/fire FSM for periodic or one-shot operation.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | not armed; matches ignored, waiting for ARM
// ST_ARMED | armed; a match pulses HIT, then stays (MODE=0) or fires (MODE=1)
// ST_DONE  | one-shot has fired; matches ignored until re-armed
module cnt_match_timer
  import cnt_match_timer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         CLK,
  input  logic         EN,
  input  logic [N-1:0] CNT,
  input  logic [N-1:0] MATCH,
  input  logic         ARM,
  input  logic         MODE,
  output logic         HIT,
  output logic         WRAP,
  output logic [W-1:0] WRAPS,
  output logic         BUSY
);

  state_t       state;
  logic [N-1:0] prev;
  logic         adv;
  logic         wrap_evt;
  logic         match_evt;
  logic         arm_acc;

  cnt_adv_detect #(.N(N)) u_adv (
    .CLK      (CLK),
    .EN       (EN),
    .CNT      (CNT),
    .prev     (prev),
    .adv      (adv),
    .wrap_evt (wrap_evt)
  );

  assign match_evt = adv & (CNT == MATCH);
  // The unused code 3 does not accept ARM; it only recovers to idle.
  assign arm_acc   = ARM & ~(&state);

  always_ff @(posedge CLK or negedge EN) begin
    if (!EN) begin
      state <= ST_IDLE;
      HIT   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      HIT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ARM) begin
            state <= ST_ARMED;
            BUSY  <= 1'b1;
          end
        end
        ST_ARMED: begin
          // A re-arm wins over a coincident match and swallows its HIT.
          if (!ARM && match_evt) begin
            HIT <= 1'b1;
            if (MODE) begin
              state <= ST_DONE;
              BUSY  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (ARM) begin
            state <= ST_ARMED;
            BUSY  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge EN) begin
    if (!EN) begin
      WRAP  <= 1'b0;
      WRAPS <= '0;
    end else begin
      WRAP <= wrap_evt;
      if (arm_acc)
        WRAPS <= '0;
      else if (wrap_evt && (WRAPS != {W{1'b1}}))
        WRAPS <= WRAPS + 1'b1;
    end
  end

endmodule
